// File: rtl/sdram_sched.sv
// SDRAM command scheduler: power-up init, interval refresh with bounded
// postponement, round-robin arbitration of the write/read paths, registered pins.
module sdram_sched #(
    parameter int ADDR_WIDTH    = 12,
    parameter int BANK_WIDTH    = 2,
    parameter int T_PLL         = 10000,
    parameter int T_RP          = 2,
    parameter int T_RFC         = 7,
    parameter int T_MRD         = 2,
    parameter int T_REFI        = 1560,
    parameter int MAX_POSTPONE  = 8,
    parameter int INIT_AR_COUNT = 2,
    parameter logic [ADDR_WIDTH-1:0] INIT_LMR = 12'h030
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_locked,
    output logic                  cke,
    output logic                  cs_n,
    output logic                  ras,
    output logic                  cas,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [BANK_WIDTH-1:0] bank,
    output logic                  sdram_ready,
    input  logic                  wr_req,
    output logic                  wr_gnt,
    input  logic [2:0]            wr_command,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic [BANK_WIDTH-1:0] wr_bank,
    input  logic                  rd_req,
    output logic                  rd_gnt,
    input  logic [2:0]            rd_command,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    input  logic [BANK_WIDTH-1:0] rd_bank,
    output logic                  refresh_pending,
    output logic [3:0]            refresh_debt,
    output logic                  refresh_overrun
);

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_AR  = 3'b001;
    localparam logic [2:0] CMD_MRS = 3'b000;
    localparam logic [3:0] DEBT_MAX = 4'(MAX_POSTPONE);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ALL_BANKS = {{(ADDR_WIDTH-11){1'b0}}, 1'b1, 10'b0};

    typedef enum logic [3:0] {
        START, WAIT_PLL, PRECHARGE, INIT_AR, LOAD_MODE,
        IDLE, OWN_WR, OWN_RD, REF_PRE, REF_AR
    } state_t;

    state_t                state, state_n;
    logic [31:0]           cnt, cnt_n;
    logic [31:0]           ar_left, ar_left_n;
    logic [31:0]           timer;
    logic                  ready_n;
    logic                  prefer_rd;
    logic                  cs_drop;
    logic                  refresh_done;
    logic                  tick;
    logic                  hold_rst;
    logic [2:0]            cmd_n, cmd_q;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [BANK_WIDTH-1:0] bank_n;

    assign hold_rst        = rst || !clk_locked;
    assign tick            = sdram_ready && (timer == 32'd0);
    assign refresh_pending = (refresh_debt != 4'd0);
    assign {ras, cas, we}  = cmd_q;

    always_comb begin
        state_n      = state;
        cnt_n        = (cnt != 32'd0) ? cnt - 32'd1 : cnt;
        ar_left_n    = ar_left;
        ready_n      = sdram_ready;
        cmd_n        = CMD_NOP;
        addr_n       = '0;
        bank_n       = '0;
        cs_drop      = 1'b0;
        refresh_done = 1'b0;
        case (state)
            START: begin
                // Entry is one cycle after cke rose, so the wait is one short.
                if (cke) begin
                    state_n = WAIT_PLL;
                    cnt_n   = 32'(T_PLL - 2);
                end
            end
            WAIT_PLL: begin
                if (cnt == 32'd0) begin
                    state_n = PRECHARGE;
                    cmd_n   = CMD_PRE;
                    addr_n  = ADDR_ALL_BANKS;
                    cs_drop = 1'b1;
                    cnt_n   = 32'(T_RP - 1);
                end
            end
            PRECHARGE: begin
                if (cnt == 32'd0) begin
                    state_n   = INIT_AR;
                    cmd_n     = CMD_AR;
                    cnt_n     = 32'(T_RFC - 1);
                    ar_left_n = 32'(INIT_AR_COUNT - 1);
                end
            end
            INIT_AR: begin
                if (cnt == 32'd0) begin
                    if (ar_left != 32'd0) begin
                        cmd_n     = CMD_AR;
                        cnt_n     = 32'(T_RFC - 1);
                        ar_left_n = ar_left - 32'd1;
                    end else begin
                        state_n = LOAD_MODE;
                        cmd_n   = CMD_MRS;
                        addr_n  = INIT_LMR;
                        cnt_n   = 32'(T_MRD - 1);
                    end
                end
            end
            LOAD_MODE: begin
                if (cnt == 32'd0) begin
                    state_n = IDLE;
                    ready_n = 1'b1;
                end
            end
            IDLE: begin
                if (refresh_debt == DEBT_MAX || (!wr_req && !rd_req && refresh_debt != 4'd0)) begin
                    state_n = REF_PRE;
                    cmd_n   = CMD_PRE;
                    addr_n  = ADDR_ALL_BANKS;
                    cnt_n   = 32'(T_RP - 1);
                end else if (wr_req && (!rd_req || !prefer_rd)) begin
                    state_n = OWN_WR;
                end else if (rd_req) begin
                    state_n = OWN_RD;
                end
            end
            OWN_WR: begin
                if (wr_req) begin
                    cmd_n  = wr_command;
                    addr_n = wr_address;
                    bank_n = wr_bank;
                end else begin
                    state_n = IDLE;
                end
            end
            OWN_RD: begin
                if (rd_req) begin
                    cmd_n  = rd_command;
                    addr_n = rd_address;
                    bank_n = rd_bank;
                end else begin
                    state_n = IDLE;
                end
            end
            REF_PRE: begin
                if (cnt == 32'd0) begin
                    state_n = REF_AR;
                    cmd_n   = CMD_AR;
                    cnt_n   = 32'(T_RFC - 1);
                end
            end
            REF_AR: begin
                if (cnt == 32'd0) begin
                    state_n      = IDLE;
                    refresh_done = 1'b1;
                end
            end
            default: state_n = START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (hold_rst) begin
            state       <= START;
            cnt         <= 32'd0;
            ar_left     <= 32'd0;
            sdram_ready <= 1'b0;
            prefer_rd   <= 1'b0;
            wr_gnt      <= 1'b0;
            rd_gnt      <= 1'b0;
            cke         <= 1'b0;
            cs_n        <= 1'b1;
            cmd_q       <= CMD_NOP;
            address     <= '0;
            bank        <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ar_left     <= ar_left_n;
            sdram_ready <= ready_n;
            wr_gnt      <= (state_n == OWN_WR);
            rd_gnt      <= (state_n == OWN_RD);
            cke         <= 1'b1;
            cmd_q       <= cmd_n;
            address     <= addr_n;
            bank        <= bank_n;
            if (cs_drop) cs_n <= 1'b0;
            if (state == IDLE && state_n == OWN_WR) prefer_rd <= 1'b1;
            if (state == IDLE && state_n == OWN_RD) prefer_rd <= 1'b0;
        end
    end

    // Refresh interval timer and debt; a tick and a completion cancel out.
    always_ff @(posedge clk) begin
        if (hold_rst) begin
            timer           <= 32'(T_REFI - 1);
            refresh_debt    <= 4'd0;
            refresh_overrun <= 1'b0;
        end else begin
            if (sdram_ready) timer <= (timer == 32'd0) ? 32'(T_REFI - 1) : timer - 32'd1;
            if (tick && !refresh_done) begin
                if (refresh_debt == DEBT_MAX) refresh_overrun <= 1'b1;
                else                          refresh_debt    <= refresh_debt + 4'd1;
            end else if (!tick && refresh_done) begin
                refresh_debt <= refresh_debt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_sched.sv
// Bench for sdram_sched: pin commands are checked against a timed expectation
// queue by a monitor; control outputs are checked at fixed cycles.
module tb_sdram_sched;

    logic        clk = 1'b0;
    logic        rst, clk_locked;
    logic        cke, cs_n, ras, cas, we, sdram_ready;
    logic [11:0] address;
    logic [1:0]  bank;
    logic        wr_req, wr_gnt, rd_req, rd_gnt;
    logic [2:0]  wr_command, rd_command;
    logic [11:0] wr_address, rd_address;
    logic [1:0]  wr_bank, rd_bank;
    logic        refresh_pending, refresh_overrun;
    logic [3:0]  refresh_debt;

    always #5 clk = ~clk;

    sdram_sched #(
        .T_PLL(10), .T_RP(2), .T_RFC(7), .T_MRD(2), .T_REFI(20),
        .MAX_POSTPONE(2), .INIT_AR_COUNT(2)
    ) dut (
        .clk(clk), .rst(rst), .clk_locked(clk_locked),
        .cke(cke), .cs_n(cs_n), .ras(ras), .cas(cas), .we(we),
        .address(address), .bank(bank), .sdram_ready(sdram_ready),
        .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_command(wr_command),
        .wr_address(wr_address), .wr_bank(wr_bank),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_command(rd_command),
        .rd_address(rd_address), .rd_bank(rd_bank),
        .refresh_pending(refresh_pending), .refresh_debt(refresh_debt),
        .refresh_overrun(refresh_overrun)
    );

    typedef struct {
        logic [2:0]  cmd;
        logic [11:0] addr;
        logic [1:0]  bank;
        logic        chk_addr;
        int          at;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_cmd(input logic [2:0] c, input logic [11:0] a,
                              input logic [1:0] b, input logic ca, input int at);
        exp_t e;
        e.cmd = c; e.addr = a; e.bank = b; e.chk_addr = ca; e.at = at;
        q.push_back(e);
    endtask

    task automatic expect_init(input int e0);
        expect_cmd(3'b010, 12'h400, 2'd0, 1'b1, e0 + 10);
        expect_cmd(3'b001, 12'h000, 2'd0, 1'b0, e0 + 12);
        expect_cmd(3'b001, 12'h000, 2'd0, 1'b0, e0 + 19);
        expect_cmd(3'b000, 12'h030, 2'd0, 1'b1, e0 + 26);
    endtask

    task automatic expect_refresh(input int pre_at);
        expect_cmd(3'b010, 12'h400, 2'd0, 1'b1, pre_at);
        expect_cmd(3'b001, 12'h000, 2'd0, 1'b0, pre_at + 2);
    endtask

    // Any non-NOP command on the selected bus must match the queue head, on time.
    always @(negedge clk) begin
        if (!cs_n && {ras, cas, we} != 3'b111) begin
            exp_t e;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_cmd cyc=%0d got cmd=%b addr=%h bank=%0d want none",
                         cyc, {ras, cas, we}, address, bank);
            end else begin
                e = q.pop_front();
                if ({ras, cas, we} != e.cmd || cyc != e.at ||
                    (e.chk_addr && (address != e.addr || bank != e.bank))) begin
                    bad++;
                    $display("FAIL pin_cmd got cmd=%b addr=%h bank=%0d at cyc %0d want cmd=%b addr=%h bank=%0d at cyc %0d",
                             {ras, cas, we}, address, bank, cyc, e.cmd, e.addr, e.bank, e.at);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_pins"}, 32'({cke, cs_n, ras, cas, we, address, bank}),
              32'({1'b0, 1'b1, 3'b111, 12'h000, 2'd0}));
        check({name, "_ctl"}, 32'({sdram_ready, wr_gnt, rd_gnt, refresh_pending,
                                   refresh_overrun, refresh_debt}), 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, r, e2;
        rst = 1'b1; clk_locked = 1'b1;
        wr_req = 1'b0; rd_req = 1'b0;
        wr_command = 3'b111; rd_command = 3'b111;
        wr_address = '0; rd_address = '0; wr_bank = '0; rd_bank = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");

        // Power-up init
        rst = 1'b0;
        e0 = cyc + 1;
        expect_init(e0);
        wait_to(e0);
        check("cke_rise", 32'({cke, cs_n}), 32'b11);
        wait_to(e0 + 27);
        check("ready_early", 32'(sdram_ready), 32'd0);
        wait_to(e0 + 28);
        check("ready", 32'(sdram_ready), 32'd1);
        r = e0 + 28;

        // Both paths request: write wins first, then read after write releases
        wr_req = 1'b1; rd_req = 1'b1;
        wait_to(r + 1);
        check("rr_first", 32'({wr_gnt, rd_gnt}), 32'b10);
        wr_command = 3'b010; wr_address = 12'h400; wr_bank = 2'd1;
        expect_cmd(3'b010, 12'h400, 2'd1, 1'b1, r + 2);
        wait_to(r + 2);
        wr_command = 3'b111;
        wait_to(r + 3);
        wr_command = 3'b011; wr_address = 12'h123; wr_bank = 2'd2;
        expect_cmd(3'b011, 12'h123, 2'd2, 1'b1, r + 4);
        wait_to(r + 4);
        wr_command = 3'b111;
        wait_to(r + 5);
        wr_req = 1'b0;
        wait_to(r + 6);
        check("release", 32'({wr_gnt, rd_gnt}), 32'b00);
        wait_to(r + 7);
        check("rr_second", 32'({wr_gnt, rd_gnt}), 32'b01);
        rd_command = 3'b101; rd_address = 12'h055; rd_bank = 2'd3;
        expect_cmd(3'b101, 12'h055, 2'd3, 1'b1, r + 8);
        wait_to(r + 8);
        rd_command = 3'b111;
        wait_to(r + 9);
        rd_req = 1'b0;

        // Postponement: write holds the bus across two refresh intervals
        wait_to(r + 11);
        wr_req = 1'b1;
        wait_to(r + 12);
        check("wr_gnt_long", 32'(wr_gnt), 32'd1);
        wait_to(r + 20);
        check("debt_1", 32'({refresh_pending, refresh_debt}), 32'h11);
        wait_to(r + 40);
        check("debt_2", 32'({refresh_overrun, refresh_pending, refresh_debt}), 32'h012);
        wr_req = 1'b0;
        expect_refresh(r + 42);
        expect_refresh(r + 52);
        expect_refresh(r + 62);
        expect_refresh(r + 81);
        wait_to(r + 51);
        check("debt_after_ref1", 32'(refresh_debt), 32'd1);
        wait_to(r + 71);
        check("debt_drained", 32'({refresh_overrun, refresh_pending, refresh_debt}), 32'h000);
        wait_to(r + 90);
        check("debt_idle_ref", 32'(refresh_debt), 32'd0);

        // Read owner held so a later refresh completion lands on a tick
        rd_req = 1'b1;
        wait_to(r + 91);
        check("rd_gnt_long", 32'(rd_gnt), 32'd1);
        wait_to(r + 109);
        rd_req = 1'b0;
        expect_refresh(r + 111);
        expect_refresh(r + 121);
        wait_to(r + 119);
        check("debt_before_coincide", 32'(refresh_debt), 32'd1);
        wait_to(r + 120);
        check("debt_coincide", 32'(refresh_debt), 32'd1);
        wait_to(r + 130);
        check("debt_after_coincide", 32'(refresh_debt), 32'd0);

        // Overrun: write holds the bus through three ticks
        wr_req = 1'b1;
        wait_to(r + 131);
        check("wr_gnt_overrun", 32'(wr_gnt), 32'd1);
        wait_to(r + 179);
        check("no_overrun_yet", 32'({refresh_overrun, refresh_debt}), 32'h02);
        wait_to(r + 180);
        check("overrun", 32'({refresh_overrun, refresh_debt, wr_gnt}), 32'h25);

        // Saturated debt refreshes before the waiting read is granted
        wait_to(r + 181);
        wr_req = 1'b0; rd_req = 1'b1;
        expect_refresh(r + 183);
        wait_to(r + 192);
        check("rd_wait_refresh", 32'({rd_gnt, refresh_debt}), 32'h01);
        wait_to(r + 193);
        check("rd_gnt_after_ref", 32'(rd_gnt), 32'd1);

        // Lock loss while the read path owns the bus
        wait_to(r + 195);
        clk_locked = 1'b0;
        wait_to(r + 196);
        check_reset_state("lock_loss");
        rd_req = 1'b0;
        wait_to(r + 197);
        clk_locked = 1'b1;
        e2 = cyc + 1;
        expect_init(e2);
        wait_to(e2);
        check("cke_rerise", 32'(cke), 32'd1);
        wait_to(e2 + 28);
        check("ready_again", 32'({sdram_ready, refresh_debt}), 32'h10);
        wait_to(e2 + 32);
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_sched.md
# sdram_sched

Parametrised SDRAM command scheduler: power-up initialisation, interval-based auto-refresh with bounded postponement, round-robin arbitration between the write-path and read-path engines, and a registered command bus to the pins. It is the next-generation control core of the wishbone SDRAM slave and sits between the `sdram_write`/`sdram_read` path engines and the SDRAM pads. It runs entirely in the SDRAM clock domain.

## Interface
- `ADDR_WIDTH`, 12: row/column address bus width.
- `BANK_WIDTH`, 2: bank select width.
- `T_PLL`, 10000: cycles from CKE rise to the first PRECHARGE.
- `T_RP`, 2: PRECHARGE to next command, in cycles.
- `T_RFC`, 7: AUTO REFRESH to next command, in cycles.
- `T_MRD`, 2: MRS to ready, in cycles.
- `T_REFI`, 1560: refresh interval in cycles; must be at least 2.
- `MAX_POSTPONE`, 8: maximum refresh debt; range 1..15.
- `INIT_AR_COUNT`, 2: number of init AUTO REFRESH commands; must be at least 1.
- `INIT_LMR`, 12'h030: mode register value driven on `address` during MRS.

Ports:
- `clk` in 1: SDRAM clock.
- `rst` in 1: synchronous, active-high reset.
- `clk_locked` in 1: clock generator lock; low is treated as reset.
- `cke`, `cs_n`, `ras`, `cas`, `we` out 1 each: SDRAM control pins, all registered.
- `address` out ADDR_WIDTH: SDRAM address, registered.
- `bank` out BANK_WIDTH: SDRAM bank, registered.
- `sdram_ready` out 1: initialisation complete.
- `wr_req` in 1: write path requests the bus.
- `wr_gnt` out 1: write path owns the bus.
- `wr_command` in 3: write path command, ordered {ras,cas,we}.
- `wr_address`, `wr_bank` in: write path address and bank.
- `rd_req`, `rd_gnt`, `rd_command`, `rd_address`, `rd_bank`: same set for the read path.
- `refresh_pending` out 1: refresh debt is greater than 0; paths close their bursts early when it is high.
- `refresh_debt` out 4: outstanding refreshes.
- `refresh_overrun` out 1: sticky; set when a refresh tick arrives while debt equals MAX_POSTPONE.

## Operation
- Command encoding {ras,cas,we}: NOP 111, PRE 010, AR 001, MRS 000.
- Issue spacing: each internal command occupies 1 cycle, then NOPs until the next command is exactly T_x cycles later.
- cke: `cke` rises 1 cycle after `!rst && clk_locked`. `clk_locked` falling applies a full reset on the next edge.
- FSM states: START, WAIT_PLL, PRECHARGE, INIT_AR, LOAD_MODE, IDLE, OWN_WR, OWN_RD, REF_PRE, REF_AR.
- Init sequence:
  - START → WAIT_PLL once `cke` = 1.
  - Wait T_PLL cycles, then drop `cs_n` to 0 and issue PRE with address[10] = 1 and bank = 0.
  - Issue INIT_AR_COUNT × AR, each T_RFC apart.
  - Issue MRS with address = INIT_LMR and bank = 0.
  - T_MRD cycles after MRS: `sdram_ready` = 1 and state = IDLE.
- Refresh timer: runs only while `sdram_ready`. It loads T_REFI-1, counts down, and at 0 reloads and raises a tick.
  - A tick increments debt.
  - Debt saturates at MAX_POSTPONE; a tick at saturation sets `refresh_overrun` instead.
  - REF_AR completing decrements debt.
  - A tick and a decrement in the same cycle leave debt unchanged.
- IDLE decision, evaluated every cycle, in priority order:
  1. debt == MAX_POSTPONE → REF_PRE.
  2. Any req present → grant one path. If both request, grant the path not granted last (initial preference: write).
  3. debt > 0 → REF_PRE.
  4. Otherwise stay in IDLE, driving NOP.
- Ownership:
  - `x_gnt` registers high on the cycle after the IDLE decision.
  - While owned, the pins carry that path's command, address and bank, each delayed 1 register stage.
  - Ownership is never preempted; the path must drop `x_req` once its burst is closed (rows precharged).
  - When `x_req` drops, `x_gnt` falls on the next edge, the state returns to IDLE, and pins show NOP.
  - A req asserted outside IDLE is held pending until the next IDLE evaluation.
- Refresh sequence: REF_PRE issues PRE all (A10 = 1); T_RP later, REF_AR issues AR; T_RFC later, debt is decremented and the state returns to IDLE.
- Non-owned pins: whenever no path owns the bus, the pins carry the internal command, or NOP.

## Timing
- Reset values: `cke` 0, `cs_n` 1, {ras,cas,we} 111, `address` 0, `bank` 0, `sdram_ready` 0, both gnt 0, debt 0, `refresh_overrun` 0, `refresh_pending` 0, refresh timer reloaded, round-robin pointer = write.
- Grant latency: req high in IDLE at edge N → gnt high after edge N+1. The path command sampled at edge M appears on the pins after edge M+1.
- Refresh pre-emption: debt reaching MAX_POSTPONE blocks new grants from the next IDLE evaluation onward. The current owner is unaffected.
- Reset mid-operation: outputs return to their reset values on the next edge; the init sequence restarts from START.

## Test plan
- Init sequence: T_PLL=10, T_RP=2, T_RFC=7, T_MRD=2, INIT_AR_COUNT=2, `clk_locked` high at C → `cke` 1 at C+1; PRE at C+11, AR at C+13 and C+20, MRS (address=INIT_LMR) at C+27, `sdram_ready` at C+29.
- Round-robin and command passthrough: `wr_req` and `rd_req` both held after ready → wr granted first. Drop `wr_req` → `rd_gnt` next. A write command (e.g. 010 with address 0x400) driven while owned appears on the pins 1 cycle later.
- Refresh postponement: T_REFI=20, MAX_POSTPONE=2, write path holds req for 45 cycles → debt reaches 2. On release: two REF_PRE/REF_AR pairs, debt returns to 0, `refresh_overrun` stays 0.
- Refresh overrun: MAX_POSTPONE=1 and req held for 3×T_REFI → `refresh_overrun` = 1 and debt stays at 1.
- Simultaneous tick and refresh completion: align a tick with the REF_AR completion cycle → debt unchanged.
- Lock loss mid-operation: deassert `clk_locked` during OWN_RD → all outputs at reset values next edge; reasserting it restarts init.
